ultrasonido_filtro: RTL and testbench

- Downstream stage of the ultrasonic ranging block; consumes one echo-width measurement per ping.
- Converts echo width in microseconds to centimetres (÷58) using a sequential restoring divider, then applies a moving average.
- Derives a debounced, hysteretic presence flag that feeds the pet-behaviour logic.
- Reports out-of-range samples and samples dropped while the block is busy.

---
 rtl/ultrasonido_pkg.sv | 25 ++
 rtl/ultrasonido_filtro_div_seq.sv | 78 +++++++
 rtl/ultrasonido_filtro.sv | 181 ++++++++++++++++++
 tb/tb_ultrasonido_filtro.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ultrasonido_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ultrasonido_pkg                                                       |
// | Shared FSM encoding and default constants for the ultrasonic filter.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package ultrasonido_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIVIDE   = 2'd1,
        ST_ACCUM    = 2'd2,
        ST_CLASSIFY = 2'd3
    } state_t;

    localparam int c_US_PER_CM = 58;
    localparam int c_MAX_US    = 23200;
    localparam int c_NEAR_CM   = 30;
    localparam int c_FAR_CM    = 40;
    localparam int c_CONFIRM   = 2;
    localparam int c_AVG_LOG2  = 2;
    localparam int c_DIST_W    = 9;

endpackage
`default_nettype wire

// File: rtl/ultrasonido_filtro_div_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_seq                                                               |
// | 16-bit by constant restoring divider, one quotient bit per cycle.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module div_seq
    import ultrasonido_pkg::*;
#(
    parameter int DIVISOR = c_US_PER_CM,
    parameter int QUO_W   = c_DIST_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [15:0]      dividend,
    output logic             done,
    output logic [QUO_W-1:0] quotient
);

    localparam int                c_REM_W = $clog2(DIVISOR);
    localparam logic [c_REM_W:0]  c_DIV_T = (c_REM_W + 1)'(DIVISOR);

    logic [c_REM_W-1:0] r_rem;
    logic [15:0]        r_dq;
    logic [3:0]         r_cnt;
    logic               r_active;

    logic [c_REM_W-1:0] w_src_rem;
    logic [15:0]        w_src_dq;
    logic [c_REM_W:0]   w_trial;
    logic [c_REM_W-1:0] w_next_rem;
    logic               w_qbit;

    // The first iteration runs on the start edge directly from the input so
    // that the last quotient bit lands 16 cycles after start.
    always_comb begin
        w_src_rem  = start ? '0 : r_rem;
        w_src_dq   = start ? dividend : r_dq;
        w_trial    = {w_src_rem, w_src_dq[15]};
        w_qbit     = 1'b0;
        w_next_rem = w_trial[c_REM_W-1:0];
        if (w_trial >= c_DIV_T) begin
            w_qbit     = 1'b1;
            w_next_rem = c_REM_W'(w_trial - c_DIV_T);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rem    <= '0;
            r_dq     <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                r_rem    <= w_next_rem;
                r_dq     <= {w_src_dq[14:0], w_qbit};
                r_cnt    <= 4'd1;
                r_active <= 1'b1;
            end else if (r_active) begin
                r_rem <= w_next_rem;
                r_dq  <= {w_src_dq[14:0], w_qbit};
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    r_active <= 1'b0;
                    done     <= 1'b1;
                end
            end
        end
    end

    assign quotient = r_dq[QUO_W-1:0];

endmodule
`default_nettype wire

// File: rtl/ultrasonido_filtro.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ultrasonido_filtro                                                    |
// | Echo width to cm, moving average and hysteretic presence detection.   |
// | Optional stale timeout enabled by macro ULTRA_TIMEOUT_EN.             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module ultrasonido_filtro
    import ultrasonido_pkg::*;
#(
    parameter int AVG_LOG2  = c_AVG_LOG2,
    parameter int NEAR_CM   = c_NEAR_CM,
    parameter int FAR_CM    = c_FAR_CM,
    parameter int CONFIRM   = c_CONFIRM,
    parameter int MAX_US    = c_MAX_US,
    parameter int US_PER_CM = c_US_PER_CM
`ifdef ULTRA_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 25_000_000
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_valid,
    input  logic [15:0]         sample_us,
    output logic                busy,
    output logic [c_DIST_W-1:0] dist_cm,
    output logic                dist_valid,
    output logic                presence,
    output logic                presence_chg,
    output logic                out_of_range,
    output logic                overrun
`ifdef ULTRA_TIMEOUT_EN
    ,
    output logic                stale
`endif
);

    localparam int                c_DEPTH     = 1 << AVG_LOG2;
    localparam int                c_SUM_W     = c_DIST_W + AVG_LOG2;
    localparam int                c_CONF_W    = $clog2(CONFIRM + 1);
    localparam logic [AVG_LOG2:0] c_FILL_FULL = c_DEPTH[AVG_LOG2:0];

    state_t              r_state;
    logic [c_DIST_W-1:0] r_buf [c_DEPTH];
    logic [AVG_LOG2-1:0] r_wr_ptr;
    logic [c_SUM_W-1:0]  r_sum;
    logic [AVG_LOG2:0]   r_fill;
    logic [c_CONF_W-1:0] r_confirm;

    logic                w_in_range;
    logic                w_accept;
    logic                w_div_done;
    logic [c_DIST_W-1:0] w_quot;
    logic [c_DIST_W-1:0] w_avg;
    logic                w_qual;
    logic                w_timeout;

    assign busy       = (r_state != ST_IDLE);
    assign w_in_range = (sample_us != 16'd0) && (sample_us <= 16'(MAX_US));
    assign w_accept   = sample_valid && (r_state == ST_IDLE) && w_in_range;
    assign w_avg      = r_sum[c_SUM_W-1:AVG_LOG2];
    assign w_qual     = presence ? (w_avg >= c_DIST_W'(FAR_CM))
                                 : (w_avg <= c_DIST_W'(NEAR_CM));

    div_seq #(
        .DIVISOR (US_PER_CM),
        .QUO_W   (c_DIST_W)
    ) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (w_accept),
        .dividend (sample_us),
        .done     (w_div_done),
        .quotient (w_quot)
    );

`ifdef ULTRA_TIMEOUT_EN
    logic [24:0] r_idle_cnt;

    // Counter parks at TIMEOUT_CYC so the timeout fires only once per silence.
    assign w_timeout = !w_accept && (r_idle_cnt == 25'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_idle_cnt <= '0;
            stale      <= 1'b0;
        end else if (w_accept) begin
            r_idle_cnt <= '0;
            stale      <= 1'b0;
        end else begin
            if (r_idle_cnt != 25'(TIMEOUT_CYC))
                r_idle_cnt <= r_idle_cnt + 25'd1;
            if (w_timeout)
                stale <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_sum        <= '0;
            r_fill       <= '0;
            r_confirm    <= '0;
            dist_cm      <= '0;
            dist_valid   <= 1'b0;
            presence     <= 1'b0;
            presence_chg <= 1'b0;
            out_of_range <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < c_DEPTH; i++)
                r_buf[i] <= '0;
        end else begin
            dist_valid   <= 1'b0;
            presence_chg <= 1'b0;
            out_of_range <= 1'b0;
            if (sample_valid && busy)
                overrun <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (sample_valid) begin
                        if (w_in_range)
                            r_state <= ST_DIVIDE;
                        else
                            out_of_range <= 1'b1;
                    end
                end
                ST_DIVIDE: begin
                    if (w_div_done)
                        r_state <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    r_sum           <= r_sum - c_SUM_W'(r_buf[r_wr_ptr]) + c_SUM_W'(w_quot);
                    r_buf[r_wr_ptr] <= w_quot;
                    r_wr_ptr        <= r_wr_ptr + 1'b1;
                    if (r_fill != c_FILL_FULL)
                        r_fill <= r_fill + 1'b1;
                    r_state <= ST_CLASSIFY;
                end
                ST_CLASSIFY: begin
                    r_state <= ST_IDLE;
                    // Until the window is full the average is meaningless.
                    if (r_fill == c_FILL_FULL) begin
                        dist_cm    <= w_avg;
                        dist_valid <= 1'b1;
                        if (w_qual) begin
                            if (r_confirm == c_CONF_W'(CONFIRM - 1)) begin
                                presence     <= ~presence;
                                presence_chg <= 1'b1;
                                r_confirm    <= '0;
                            end else begin
                                r_confirm <= r_confirm + 1'b1;
                            end
                        end else begin
                            r_confirm <= '0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_timeout) begin
                presence     <= 1'b0;
                presence_chg <= presence;
                r_wr_ptr     <= '0;
                r_sum        <= '0;
                r_fill       <= '0;
                r_confirm    <= '0;
                for (int i = 0; i < c_DEPTH; i++)
                    r_buf[i] <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ultrasonido_filtro.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ultrasonido_filtro                                                 |
// | Directed self-checking bench for the ultrasonic distance filter.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_ultrasonido_filtro;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_us = 16'd0;
    logic        busy;
    logic [8:0]  dist_cm;
    logic        dist_valid;
    logic        presence;
    logic        presence_chg;
    logic        out_of_range;
    logic        overrun;
`ifdef ULTRA_TIMEOUT_EN
    logic        stale;
`endif

    int checks = 0;
    int failures = 0;

    always #10 clk = ~clk;

`ifdef ULTRA_TIMEOUT_EN
    ultrasonido_filtro #(.TIMEOUT_CYC(100)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_us    (sample_us),
        .busy         (busy),
        .dist_cm      (dist_cm),
        .dist_valid   (dist_valid),
        .presence     (presence),
        .presence_chg (presence_chg),
        .out_of_range (out_of_range),
        .overrun      (overrun),
        .stale        (stale)
    );
`else
    ultrasonido_filtro dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_us    (sample_us),
        .busy         (busy),
        .dist_cm      (dist_cm),
        .dist_valid   (dist_valid),
        .presence     (presence),
        .presence_chg (presence_chg),
        .out_of_range (out_of_range),
        .overrun      (overrun)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Issue one accepted sample and follow it to the cycle where dist_valid is due.
    task automatic ping(input logic [15:0] us, input bit exp_dv, input int exp_dist,
                        input bit exp_pres, input bit exp_chg, input string tag);
        bit early_dv;
        early_dv     = 1'b0;
        sample_valid = 1'b1;
        sample_us    = us;
        @(posedge clk);
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            if (k < 19) early_dv = early_dv | dist_valid;
            if (k == 1)  chk({tag, "_busy_c1"}, busy, 1);
            if (k == 18) chk({tag, "_busy_c18"}, busy, 1);
        end
        chk({tag, "_early_dv"}, early_dv, 0);
        chk({tag, "_busy_c19"}, busy, 0);
        chk({tag, "_dv"}, dist_valid, exp_dv);
        if (exp_dv) chk({tag, "_dist"}, dist_cm, exp_dist);
        chk({tag, "_pres"}, presence, exp_pres);
        chk({tag, "_chg"}, presence_chg, exp_chg);
    endtask

    task automatic reject(input logic [15:0] us, input int hold_dist, input string tag);
        sample_valid = 1'b1;
        sample_us    = us;
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        chk({tag, "_oor"}, out_of_range, 1);
        chk({tag, "_busy"}, busy, 0);
        @(negedge clk);
        chk({tag, "_oor_clr"}, out_of_range, 0);
        chk({tag, "_dist"}, dist_cm, hold_dist);
    endtask

    initial begin
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_dist", dist_cm, 0);
        chk("rst_dv", dist_valid, 0);
        chk("rst_pres", presence, 0);
        chk("rst_chg", presence_chg, 0);
        chk("rst_oor", out_of_range, 0);
        chk("rst_ovr", overrun, 0);

        ping(16'd580, 0, 0, 0, 0, "warm1");

        do_reset();
        ping(16'd2900, 0, 0, 0, 0, "fill1");
        ping(16'd2900, 0, 0, 0, 0, "fill2");
        ping(16'd2900, 0, 0, 0, 0, "fill3");
        ping(16'd2900, 1, 50, 0, 0, "avg50");

        ping(16'd1160, 1, 42, 0, 0, "avg42");
        ping(16'd1160, 1, 35, 0, 0, "avg35");
        ping(16'd1160, 1, 27, 0, 0, "avg27");
        ping(16'd1160, 1, 20, 1, 1, "rise");

        // Window [20,20,20,20] -> [60,20,20,20] ...
        ping(16'd3480, 1, 30, 1, 0, "h30");
        ping(16'd3537, 1, 40, 1, 0, "h40");
        ping(16'd116,  1, 35, 1, 0, "h35");
        ping(16'd2900, 1, 43, 1, 0, "h43");
        ping(16'd2900, 1, 40, 0, 1, "fall");

        reject(16'd0, 40, "zero");
        reject(16'd23201, 40, "over");

        // 23200 us (400 cm) accepted; a second strobe 5 cycles later is dropped.
        sample_valid = 1'b1;
        sample_us    = 16'd23200;
        @(posedge clk);
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            if (k == 1) begin
                chk("max_busy", busy, 1);
                chk("ovr_before", overrun, 0);
            end
            if (k == 5) begin
                sample_valid = 1'b1;
                sample_us    = 16'd580;
            end
            if (k == 6) chk("ovr_set", overrun, 1);
        end
        chk("max_dv", dist_valid, 1);
        chk("max_dist", dist_cm, 125);

        ping(16'd2900, 1, 137, 0, 0, "post_ovr");
        chk("ovr_sticky", overrun, 1);

        do_reset();
        chk("ovr_rst", overrun, 0);
        ping(16'd1160, 0, 0, 0, 0, "r2_1");
        ping(16'd1160, 0, 0, 0, 0, "r2_2");
        ping(16'd1160, 0, 0, 0, 0, "r2_3");
        ping(16'd1160, 1, 20, 0, 0, "r2_4");
        ping(16'd1160, 1, 20, 1, 1, "r2_rise");

`ifdef ULTRA_TIMEOUT_EN
        begin
            int k;
            k = 19;
            while (!stale && k < 300) begin
                @(negedge clk);
                k++;
            end
            chk("to_stale", stale, 1);
            chk("to_cycle", k, 101);
            chk("to_pres", presence, 0);
            chk("to_chg", presence_chg, 1);
            @(negedge clk);
            chk("to_chg_clr", presence_chg, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
